// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode constants and the queue entry layout.
// Imported by the fetch queue, its storage and its interface.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  // Shown to decode whenever the queue holds nothing.
  localparam fq_entry_t FQ_EMPTY_ENTRY = '{pc: '0, inst: INST_NOP};

  function automatic fq_entry_t fq_pack(input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] inst);
    fq_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
// The queue uses the slave modport; the fetch/decode/execute side uses master.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);

  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            br_ctrl;
  logic            pc_stall;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [CW-1:0]   fq_count;

  modport master (
    output if_pc, if_inst, br_ctrl, id_ready,
    input  pc_stall, id_valid, id_pc, id_inst, fq_count
  );

  modport slave (
    input  if_pc, if_inst, br_ctrl, id_ready,
    output pc_stall, id_valid, id_pc, id_inst, fq_count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: flop array, synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the queue's count.
module fq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fq_entry_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fq_entry_t     rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO; head visible 1 cycle after push, no bypass.
// pc_stall while full (no id_ready path); br_ctrl or rst empties the queue on the next edge.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave fq
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic      full;
  logic      empty;
  logic      flush;
  logic      push;
  logic      pop;
  fq_entry_t wr_entry;
  fq_entry_t rd_entry;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign flush = fq.br_ctrl;

  // Full blocks the push even when a pop frees a slot this cycle: fetch is
  // already stalled and re-presents the same instruction next cycle.
  assign push = ~rst & ~flush & ~full;
  assign pop  = ~rst & ~flush & ~empty & fq.id_ready;

  assign wr_entry = fq_pack(fq.if_pc, fq.if_inst);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  fq_entry_t head;
  assign head = empty ? FQ_EMPTY_ENTRY : rd_entry;

  assign fq.id_valid = ~empty;
  assign fq.id_pc    = head.pc;
  assign fq.id_inst  = head.inst;
  assign fq.pc_stall = full & ~flush;
  assign fq.fq_count = count_q;

  count_bounded: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  flush_empties: assert property (@(posedge clk)
    flush |=> (count_q == '0));

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the instruction-fetch stage and the decode stage. Each cycle it captures the fetch stage's `{if_pc, if_inst}` pair into a small FIFO and drives `pc_stall` back to fetch when full. It presents the oldest entry to decode with a valid/ready handshake. On a taken branch it flushes all queued (wrong-path) instructions.

## Interface
- `DEPTH`, 4 — number of entries; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH+1)` — width of the occupancy count.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, synchronous and active-high.
- `if_pc` in 32 — PC currently presented by fetch.
- `if_inst` in 32 — instruction at `if_pc` from fetch.
- `br_ctrl` in 1 — taken-branch redirect from execute; flushes the queue.
- `pc_stall` out 1 — holds the fetch PC.
- `id_valid` out 1 — head entry present.
- `id_ready` in 1 — decode accepts the head this cycle.
- `id_pc` out 32 — head PC.
- `id_inst` out 32 — head instruction.
- `fq_count` out CW — current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 64-bit flop array; read and write pointers `log2(DEPTH)` bits wide, wrapping modulo DEPTH; separate `count` register.
- Fetch has no valid signal. Every cycle's `{if_pc, if_inst}` is a real instruction unless the PC is stalled or being redirected.
- `push = ~rst & ~br_ctrl & (count != DEPTH)`.
- `pop = ~rst & ~br_ctrl & id_valid & id_ready`.
- `pc_stall = (count == DEPTH) & ~br_ctrl`.
  - This is combinational from `count` and `br_ctrl` only; there is no path from `id_ready`.
  - While full, fetch holds its PC and the same instruction re-presents. It is not pushed until a slot frees, so no duplicate is ever enqueued.
- Full with pop in the same cycle: no push that cycle (one-cycle bubble is accepted). `pc_stall` drops the next cycle.
- Push and pop in the same cycle (not full, not empty): write and read both advance; `count` is unchanged.
- Empty with `id_ready=1`: no pop. There is no fall-through bypass; a pushed entry is first visible the cycle after the push.
- Outputs:
  - `id_valid = (count != 0)`.
  - When valid, `id_pc`/`id_inst` = `mem[rd_ptr]`, read combinationally from flops.
  - When empty, `id_pc = 32'h0` and `id_inst = INST_NOP` (`32'h00000013`).
- Flush (`br_ctrl=1`):
  - Next edge: `rd_ptr`, `wr_ptr`, `count` ← 0.
  - No push and no pop that cycle; the current `if_inst` is wrong-path and is dropped.
  - Flush has priority over push, pop and full.
  - Fetch loads `br_addr` on the same edge. The instruction at the target is pushed the following cycle.
- Back-to-back `br_ctrl`: every flagged cycle flushes; the queue stays empty throughout.
- Reset:
  - During `rst`: no push, no pop.
  - Next edge: pointers and count ← 0.
  - Outputs after reset: `id_valid=0`, `pc_stall=0`, `fq_count=0`, `id_pc=0`, `id_inst=INST_NOP`.
  - Memory contents are not reset.
  - `rst` asserted mid-operation discards all entries exactly like a flush.

## Timing
- Push-to-head latency is 1 cycle when empty. With the queue continuously popped, steady-state throughput is 1 instruction/cycle.
- `fq_count` changes only on clock edges: +1 on push only, −1 on pop only, unchanged on both or neither, 0 on flush or reset.
- `pc_stall` is asserted in the same cycle `count` reaches DEPTH.
- `br_ctrl` → queue empty and `id_valid=0` on the cycle after `br_ctrl`.
- Decode-side rule: decode samples `id_pc`/`id_inst` in any cycle where `id_valid & id_ready`. Head values are stable until popped or flushed.

## Structure
- Shared package/defines: `INST_NOP = 32'h00000013`, `XLEN = 32`. The fetch, decode and hazard logic use the same constants.
- One sub-module is natural: `fq_mem`, holding the DEPTH × 64 flop array with a synchronous write port and an asynchronous read port.
- Pointer, count, and handshake logic stay in `fetch_queue`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with random inputs → `id_valid=0`, `pc_stall=0`, `fq_count=0`, `id_inst=32'h00000013`. The first post-reset `if_pc=0x0` appears at the head one cycle later.
- **Fill:** `id_ready=0`, fetch PCs 0x00, 0x04, 0x08, 0x0C → `fq_count`=4 and `pc_stall=1` on the 4th cycle. Holding at `if_pc=0x10` for 3 cycles pushes nothing. Then `id_ready=1` pops 0x00, no push that cycle, and 0x10 is pushed the next cycle exactly once.
- **Streaming:** `id_ready=1` constantly, PCs 0x100 upward by 4 for 20 cycles → decode receives 0x100..0x14C in order, each once. `fq_count` stays 1 after the first cycle, and wrap-around is exercised.
- **Flush while full:** queue full with `br_ctrl=1`, `id_ready=1` → no pop accepted, `fq_count=0` and `id_valid=0` next cycle. Branch target 0x200 appears at the head two cycles after `br_ctrl`.
- **Simultaneous push/pop at count=2:** → `fq_count` stays 2 and FIFO order is preserved.
- **Reset mid-operation:** assert `rst` with count=3 → count=0 after the edge; no stale entry is ever presented as valid.
